elevator_scan_ctrl: RTL and testbench
=====================================

Name: elevator_scan_ctrl

Overview:
Parametrised N-floor elevator car controller and successor to the single-request controller. Latches hall/car calls into a pending-request bitmap and serves them in SCAN (elevator) order. Models travel time per floor and door dwell time with counters, and has a latched emergency mode. Sits between the call-button aggregation logic and the motor/door drive logic of one car.

Parameters:
NUM_FLOORS, 16, number of floors (2..256); floors are numbered 0..NUM_FLOORS-1.
FLOOR_W, $clog2(NUM_FLOORS), width of floor index (derived; do not override).
TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
DOOR_CYCLES, 8, clock cycles the door stays open per stop (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
emergency  in  1  level; while high the car halts and the door is held open
call_req  in  NUM_FLOORS  one bit per floor; any high bit is latched as a pending call (pulse or level)
current_floor  out  FLOOR_W  floor the car is at or last passed
direction  out  2  00 idle, 01 up, 10 down (11 never driven)
door_open  out  1  door open
moving  out  1  high while in MOVE state
arrived  out  1  one-cycle pulse on the edge the car stops at a served floor
pending  out  NUM_FLOORS  current pending-call bitmap

Behaviour:
- All outputs are registered. Reset (sync, active-high) sets state=IDLE, current_floor=0, direction=00, door_open=0, moving=0, arrived=0, pending=0, and clears all counters. Reset asserted mid-travel or mid-dwell aborts the operation immediately; no floor update occurs.
- Call latching: pending <= (pending | call_req) & ~clear_mask on every edge, except in EMERG. A call bit and a clear on the same floor in the same cycle: clear wins.
- States: IDLE, MOVE, DOOR, EMERG.
- "Ahead" means any pending bit strictly above current_floor (up) or strictly below it (down).
- IDLE:
  - if pending[current_floor] -> DOOR next edge; clear that bit; door_open=1; arrived=1.
  - else if any pending bit above -> MOVE, direction=01.
  - else if any pending bit below -> MOVE, direction=10.
  - else stay in IDLE with direction=00.
  - Up has priority when calls exist both above and below.
- MOVE:
  - travel_cnt increments every cycle.
  - At the edge where travel_cnt==TRAVEL_CYCLES-1: current_floor steps ±1 and travel_cnt resets to 0.
  - First floor change occurs TRAVEL_CYCLES edges after entering MOVE.
  - If pending[new floor] is set: on the same edge go to DOOR, door_open=1, arrived=1, moving=0, and clear the bit. Otherwise keep moving.
  - current_floor never goes below 0 or above NUM_FLOORS-1; SCAN logic guarantees this, and the implementation must assert it.
- DOOR:
  - dwell_cnt counts DOOR_CYCLES cycles.
  - A new call_req bit for current_floor while in DOOR is not latched; it restarts dwell_cnt.
  - On dwell expiry, door_open=0 and the next move is chosen:
    - calls ahead in the current direction -> MOVE, same direction;
    - else calls behind -> MOVE, reversed direction;
    - else -> IDLE with direction=00.
- EMERG:
  - emergency high in any state -> EMERG on the next edge.
  - On entry: door_open=1, moving=0, direction=00, pending cleared, counters cleared.
  - A partial travel is abandoned; current_floor keeps its last value.
  - call_req is ignored while in EMERG.
  - On the edge after emergency falls: -> IDLE, door_open=0.
- arrived is high for exactly one cycle per stop. It is never asserted in EMERG.

Decomposition:
- Package elevator_pkg:
  - state enum (IDLE/MOVE/DOOR/EMERG);
  - direction constants DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10.
- Sub-module elevator_req_scan: purely combinational. Inputs are pending and current_floor. Outputs are any_above, any_below, and hit_here. It is shared with the future multi-car dispatcher.
- The counters stay in the top level.

Test Plan:
- Reset then call_req[3] pulse at edge N (TRAVEL_CYCLES=4, DOOR_CYCLES=8) -> MOVE at N+1; current_floor=1,2,3 at N+5, N+9, N+13; door_open=1 and arrived pulse at N+13; door_open=0 and IDLE at N+21.
- Car at floor 5 in IDLE, call_req[5] -> DOOR next edge, pending[5] cleared, no movement. Re-press floor 5 at dwell cycle 6 -> dwell restarts, door stays open 8 more cycles.
- SCAN order: car at 4 moving up, pending {2,6,9} -> stops at 6 then 9, reverses, then stops at 2. direction goes 01 -> 10 -> 00 after the final dwell.
- Emergency asserted at travel_cnt=2 between floors 7 and 8 -> next edge EMERG, current_floor=7, door_open=1, pending=0. call_req ignored while in EMERG. Emergency low -> IDLE, door_open=0.
- Boundaries with NUM_FLOORS=4: call floor 3 from 0 reaches 3 and never exceeds it. Then call floor 0 -> descends to 0, never wraps.
- Reset asserted mid-MOVE -> next edge all outputs at reset values, including pending=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controllers:
// FSM state encoding and the direction codes driven on the direction output.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOOR  = 2'd2,
    EMERG = 2'd3
  } state_e;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational scan of a pending-call bitmap relative to one floor.
// Kept standalone so the multi-car dispatcher can reuse it.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  hit_here
);

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    hit_here  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(current_floor)) any_above = any_above | pending[i];
      if (i < int'(current_floor)) any_below = any_below | pending[i];
      if (i == int'(current_floor)) hit_here = pending[i];
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches calls, serves them in sweep order,
// times travel and door dwell with counters, and supports a latched emergency halt.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  emergency,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic                  moving,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DWELL_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAV_W-1:0] TRAVEL_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_LAST = FLOOR_W'(NUM_FLOORS - 1);

  state_e                state, state_n;
  logic [TRAV_W-1:0]     travel_cnt, travel_n;
  logic [DWELL_W-1:0]    dwell_cnt, dwell_n;
  logic [FLOOR_W-1:0]    floor_n, step_floor;
  logic [1:0]            dir_n;
  logic                  door_n, moving_n, arrived_n;
  logic [NUM_FLOORS-1:0] pending_n, clear_mask, floor_mask, step_mask;
  logic                  any_above, any_below, hit_here;
  logic                  step_hit, go_up, go_down;

  elevator_req_scan #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_scan (
    .pending      (pending),
    .current_floor(current_floor),
    .any_above    (any_above),
    .any_below    (any_below),
    .hit_here     (hit_here)
  );

  // The floor the car reaches at the end of the current travel interval.
  always_comb begin
    step_floor = (direction == DIR_UP) ? current_floor + FLOOR_W'(1)
                                       : current_floor - FLOOR_W'(1);
    floor_mask = NUM_FLOORS'(1) << current_floor;
    step_mask  = NUM_FLOORS'(1) << step_floor;
    step_hit   = |(pending & step_mask);
    // Keep sweeping down if already heading down, otherwise up wins ties.
    if (direction == DIR_DOWN) begin
      go_down = any_below;
      go_up   = !any_below && any_above;
    end else begin
      go_up   = any_above;
      go_down = !any_above && any_below;
    end
  end

  always_comb begin
    state_n    = state;
    floor_n    = current_floor;
    dir_n      = direction;
    door_n     = door_open;
    moving_n   = moving;
    arrived_n  = 1'b0;
    travel_n   = travel_cnt;
    dwell_n    = dwell_cnt;
    clear_mask = '0;

    unique case (state)
      IDLE: begin
        if (hit_here) begin
          state_n    = DOOR;
          door_n     = 1'b1;
          arrived_n  = 1'b1;
          dwell_n    = '0;
          clear_mask = floor_mask;
        end else if (any_above) begin
          state_n  = MOVE;
          dir_n    = DIR_UP;
          moving_n = 1'b1;
          travel_n = '0;
        end else if (any_below) begin
          state_n  = MOVE;
          dir_n    = DIR_DOWN;
          moving_n = 1'b1;
          travel_n = '0;
        end else begin
          dir_n = DIR_IDLE;
        end
      end

      MOVE: begin
        if (travel_cnt == TRAVEL_LAST) begin
          travel_n = '0;
          floor_n  = step_floor;
          if (step_hit) begin
            state_n    = DOOR;
            door_n     = 1'b1;
            arrived_n  = 1'b1;
            moving_n   = 1'b0;
            dwell_n    = '0;
            clear_mask = step_mask;
          end
        end else begin
          travel_n = travel_cnt + TRAV_W'(1);
        end
      end

      DOOR: begin
        // A re-press of this floor holds the door rather than queueing a new stop.
        clear_mask = floor_mask;
        if (|(call_req & floor_mask)) begin
          dwell_n = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          door_n  = 1'b0;
          dwell_n = '0;
          if (go_up || go_down) begin
            state_n  = MOVE;
            dir_n    = go_up ? DIR_UP : DIR_DOWN;
            moving_n = 1'b1;
            travel_n = '0;
          end else begin
            state_n = IDLE;
            dir_n   = DIR_IDLE;
          end
        end else begin
          dwell_n = dwell_cnt + DWELL_W'(1);
        end
      end

      EMERG: begin
        if (!emergency) begin
          state_n = IDLE;
          door_n  = 1'b0;
        end
      end
    endcase

    if (emergency) begin
      state_n   = EMERG;
      floor_n   = current_floor;
      dir_n     = DIR_IDLE;
      door_n    = 1'b1;
      moving_n  = 1'b0;
      arrived_n = 1'b0;
      travel_n  = '0;
      dwell_n   = '0;
    end

    if (emergency || state == EMERG) pending_n = '0;
    else pending_n = (pending | call_req) & ~clear_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      direction     <= DIR_IDLE;
      door_open     <= 1'b0;
      moving        <= 1'b0;
      arrived       <= 1'b0;
      pending       <= '0;
      travel_cnt    <= '0;
      dwell_cnt     <= '0;
    end else begin
      state         <= state_n;
      current_floor <= floor_n;
      direction     <= dir_n;
      door_open     <= door_n;
      moving        <= moving_n;
      arrived       <= arrived_n;
      pending       <= pending_n;
      travel_cnt    <= travel_n;
      dwell_cnt     <= dwell_n;
    end
  end

  // SCAN only moves toward a pending call, so a step can never leave the shaft.
  always_ff @(posedge clk) begin
    if (!reset && state == MOVE && travel_cnt == TRAVEL_LAST) begin
      assert (direction == DIR_UP || direction == DIR_DOWN);
      assert (!(direction == DIR_UP && current_floor == FLOOR_LAST));
      assert (!(direction == DIR_DOWN && current_floor == '0));
    end
    assert (direction != 2'b11);
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: a 16-floor car for the main scenarios
// and a 4-floor car for the shaft-end boundaries.
module tb_elevator_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        emergency = 1'b0;
  logic [15:0] call_req = '0;
  logic [3:0]  current_floor;
  logic [1:0]  direction;
  logic        door_open, moving, arrived;
  logic [15:0] pending;

  logic        reset4 = 1'b1;
  logic        emergency4 = 1'b0;
  logic [3:0]  call4 = '0;
  logic [1:0]  floor4;
  logic [1:0]  dir4;
  logic        door4, moving4, arrived4;
  logic [3:0]  pending4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  elevator_scan_ctrl #(.NUM_FLOORS(16), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .emergency(emergency), .call_req(call_req),
    .current_floor(current_floor), .direction(direction), .door_open(door_open),
    .moving(moving), .arrived(arrived), .pending(pending)
  );

  elevator_scan_ctrl #(.NUM_FLOORS(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut4 (
    .clk(clk), .reset(reset4), .emergency(emergency4), .call_req(call4),
    .current_floor(floor4), .direction(dir4), .door_open(door4),
    .moving(moving4), .arrived(arrived4), .pending(pending4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arrival(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (arrived === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++; if (current_floor !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_floor: got %0d expected 0", current_floor); end
    tests_run++; if (direction !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_dir: got %b expected 00", direction); end
    tests_run++; if ({door_open, moving, arrived} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {door_open, moving, arrived}); end
    tests_run++; if (pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_pending: got %h expected 0000", pending); end
    reset = 1'b0;
  endtask

  task automatic test_single_call();
    call_req = 16'h0008;
    step();
    call_req = '0;
    tests_run++; if (pending !== 16'h0008) begin tests_failed++; $display("[TB] FAIL single_latch: got %h expected 0008", pending); end
    tests_run++; if (moving !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_not_yet_moving: got %b expected 0", moving); end
    step();
    tests_run++; if ({moving, direction} !== 3'b101) begin tests_failed++; $display("[TB] FAIL single_move_start: got %b expected 101", {moving, direction}); end
    repeat (3) step();
    tests_run++; if (current_floor !== 4'd0) begin tests_failed++; $display("[TB] FAIL single_floor0_hold: got %0d expected 0", current_floor); end
    step();
    tests_run++; if (current_floor !== 4'd1) begin tests_failed++; $display("[TB] FAIL single_floor1: got %0d expected 1", current_floor); end
    repeat (4) step();
    tests_run++; if (current_floor !== 4'd2) begin tests_failed++; $display("[TB] FAIL single_floor2: got %0d expected 2", current_floor); end
    tests_run++; if (arrived !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_no_stop_at2: got %b expected 0", arrived); end
    repeat (4) step();
    tests_run++; if (current_floor !== 4'd3) begin tests_failed++; $display("[TB] FAIL single_floor3: got %0d expected 3", current_floor); end
    tests_run++; if ({door_open, arrived, moving} !== 3'b110) begin tests_failed++; $display("[TB] FAIL single_arrive: got %b expected 110", {door_open, arrived, moving}); end
    tests_run++; if (pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL single_clear: got %h expected 0000", pending); end
    step();
    tests_run++; if ({door_open, arrived} !== 2'b10) begin tests_failed++; $display("[TB] FAIL single_arrived_pulse: got %b expected 10", {door_open, arrived}); end
    repeat (6) step();
    tests_run++; if (door_open !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_dwell_open: got %b expected 1", door_open); end
    step();
    tests_run++; if ({door_open, moving, direction} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_close_idle: got %b expected 0000", {door_open, moving, direction}); end
  endtask

  task automatic test_door_restart();
    bit ok;
    call_req = 16'h0020;
    step();
    call_req = '0;
    wait_arrival(40, ok);
    tests_run++; if (!ok || current_floor !== 4'd5) begin tests_failed++; $display("[TB] FAIL restart_reach5: got floor %0d arrived %b expected floor 5 arrived 1", current_floor, ok); end
    repeat (8) step();
    call_req = 16'h0020;
    step();
    call_req = '0;
    tests_run++; if (pending !== 16'h0020) begin tests_failed++; $display("[TB] FAIL restart_latch5: got %h expected 0020", pending); end
    step();
    tests_run++; if ({door_open, arrived, moving, direction} !== 5'b11000) begin tests_failed++; $display("[TB] FAIL restart_open_here: got %b expected 11000", {door_open, arrived, moving, direction}); end
    tests_run++; if (pending !== 16'h0000 || current_floor !== 4'd5) begin tests_failed++; $display("[TB] FAIL restart_clear_here: got pending %h floor %0d expected 0000 floor 5", pending, current_floor); end
    repeat (6) step();
    call_req = 16'h0020;
    step();
    call_req = '0;
    tests_run++; if (pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL restart_not_latched: got %h expected 0000", pending); end
    step();
    tests_run++; if (door_open !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_extended: got %b expected 1", door_open); end
    repeat (6) step();
    tests_run++; if (door_open !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_still_open: got %b expected 1", door_open); end
    step();
    tests_run++; if ({door_open, moving} !== 2'b00) begin tests_failed++; $display("[TB] FAIL restart_close: got %b expected 00", {door_open, moving}); end
  endtask

  task automatic test_scan_order();
    bit ok;
    call_req = 16'h0010;
    step();
    call_req = '0;
    wait_arrival(40, ok);
    tests_run++; if (!ok || current_floor !== 4'd4 || direction !== 2'b10) begin tests_failed++; $display("[TB] FAIL scan_reach4: got floor %0d dir %b ok %b expected floor 4 dir 10", current_floor, direction, ok); end
    repeat (8) step();
    call_req = 16'h0244;
    step();
    call_req = '0;
    step();
    tests_run++; if ({moving, direction} !== 3'b101) begin tests_failed++; $display("[TB] FAIL scan_up_first: got %b expected 101", {moving, direction}); end
    wait_arrival(40, ok);
    tests_run++; if (!ok || current_floor !== 4'd6 || pending !== 16'h0204) begin tests_failed++; $display("[TB] FAIL scan_stop6: got floor %0d pending %h expected floor 6 pending 0204", current_floor, pending); end
    wait_arrival(40, ok);
    tests_run++; if (!ok || current_floor !== 4'd9 || direction !== 2'b01) begin tests_failed++; $display("[TB] FAIL scan_stop9: got floor %0d dir %b expected floor 9 dir 01", current_floor, direction); end
    repeat (8) step();
    tests_run++; if ({door_open, moving, direction} !== 4'b0110) begin tests_failed++; $display("[TB] FAIL scan_reverse: got %b expected 0110", {door_open, moving, direction}); end
    wait_arrival(60, ok);
    tests_run++; if (!ok || current_floor !== 4'd2 || pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL scan_stop2: got floor %0d pending %h expected floor 2 pending 0000", current_floor, pending); end
    repeat (8) step();
    tests_run++; if ({door_open, moving, direction} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL scan_final_idle: got %b expected 0000", {door_open, moving, direction}); end
  endtask

  task automatic test_emergency();
    bit ok;
    call_req = 16'h0400;
    step();
    call_req = '0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (current_floor === 4'd7) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL emerg_reach7: got floor %0d expected 7", current_floor); end
    repeat (2) step();
    emergency = 1'b1;
    call_req = 16'h1000;
    step();
    call_req = '0;
    tests_run++; if (current_floor !== 4'd7) begin tests_failed++; $display("[TB] FAIL emerg_floor_kept: got %0d expected 7", current_floor); end
    tests_run++; if ({door_open, moving, arrived, direction} !== 5'b10000) begin tests_failed++; $display("[TB] FAIL emerg_entry: got %b expected 10000", {door_open, moving, arrived, direction}); end
    tests_run++; if (pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL emerg_pending_clear: got %h expected 0000", pending); end
    call_req = 16'hFFFF;
    repeat (3) step();
    call_req = '0;
    tests_run++; if (pending !== 16'h0000 || door_open !== 1'b1 || current_floor !== 4'd7) begin tests_failed++; $display("[TB] FAIL emerg_ignore_calls: got pending %h door %b floor %0d expected 0000 1 7", pending, door_open, current_floor); end
    emergency = 1'b0;
    step();
    tests_run++; if ({door_open, moving, direction} !== 4'b0000 || pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL emerg_exit: got flags %b pending %h expected 0000 0000", {door_open, moving, direction}, pending); end
    repeat (5) step();
    tests_run++; if (current_floor !== 4'd7 || moving !== 1'b0) begin tests_failed++; $display("[TB] FAIL emerg_stays_idle: got floor %0d moving %b expected 7 0", current_floor, moving); end
  endtask

  task automatic test_reset_mid_move();
    call_req = 16'h5000;
    step();
    call_req = '0;
    step();
    repeat (3) step();
    tests_run++; if (moving !== 1'b1 || current_floor !== 4'd7) begin tests_failed++; $display("[TB] FAIL rst_pre_moving: got moving %b floor %0d expected 1 7", moving, current_floor); end
    reset = 1'b1;
    step();
    tests_run++; if ({current_floor, direction, door_open, moving, arrived} !== 9'd0 || pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL rst_mid_move: got floor %0d dir %b flags %b pending %h expected all zero", current_floor, direction, {door_open, moving, arrived}, pending); end
    reset = 1'b0;
    repeat (6) step();
    tests_run++; if (current_floor !== 4'd0 || moving !== 1'b0 || pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL rst_after: got floor %0d moving %b pending %h expected 0 0 0000", current_floor, moving, pending); end
  endtask

  task automatic test_boundaries();
    bit ok, bad;
    logic [1:0] prev;
    step();
    reset4 = 1'b0;
    call4 = 4'b1000;
    step();
    call4 = '0;
    ok = 1'b0; bad = 1'b0; prev = floor4;
    for (int i = 0; i < 40; i++) begin
      step();
      if (floor4 < prev) bad = 1'b1;
      prev = floor4;
      if (arrived4 === 1'b1) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok || bad || floor4 !== 2'd3) begin tests_failed++; $display("[TB] FAIL bound_top: got floor %0d ok %b regress %b expected floor 3 ok 1 regress 0", floor4, ok, bad); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (floor4 !== 2'd3) bad = 1'b1;
    end
    tests_run++; if (bad || dir4 !== 2'b00 || moving4 !== 1'b0) begin tests_failed++; $display("[TB] FAIL bound_top_hold: got floor %0d dir %b moving %b expected 3 00 0", floor4, dir4, moving4); end
    call4 = 4'b0001;
    step();
    call4 = '0;
    ok = 1'b0; bad = 1'b0; prev = floor4;
    for (int i = 0; i < 40; i++) begin
      step();
      if (floor4 > prev) bad = 1'b1;
      prev = floor4;
      if (arrived4 === 1'b1) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok || bad || floor4 !== 2'd0 || dir4 !== 2'b10) begin tests_failed++; $display("[TB] FAIL bound_bottom: got floor %0d dir %b ok %b regress %b expected floor 0 dir 10", floor4, dir4, ok, bad); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (floor4 !== 2'd0) bad = 1'b1;
    end
    tests_run++; if (bad || dir4 !== 2'b00 || pending4 !== 4'b0000) begin tests_failed++; $display("[TB] FAIL bound_bottom_hold: got floor %0d dir %b pending %b expected 0 00 0000", floor4, dir4, pending4); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_door_restart();
    test_scan_order();
    test_emergency();
    test_reset_mid_move();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
